// File: rtl/writeback_commit.sv
// Writeback/commit stage: commits the EX/WB bundle to the 32x32 register file, traps on exception bits, counts retirements.
// Writes land one edge after the commit cycle; optional same-cycle read forwarding under WB_BYPASS_EN.
module writeback_commit #(
    parameter int unsigned KILL_CYCLES = 3,
    parameter logic [31:0] HANDLER_PC  = 32'h0000_2000
) (
    input  logic        clk_i,
    input  logic        rsn_i,
    input  logic [31:0] write_int_write_data_i,
    input  logic [4:0]  write_write_addr_i,
    input  logic        write_int_write_enable_i,
    input  logic [31:0] write_exc_bits_i,
    input  logic [31:0] write_instruction_i,
    input  logic [31:0] write_pc_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    output logic        kill_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mcause_o,
    output logic [31:0] mtval_o,
    output logic [63:0] minstret_o
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] regs [32];
    logic        is_idle;
    logic        clean;
    logic        fault;
    logic [4:0]  cause;

    assign is_idle = (state == IDLE);
    assign clean   = is_idle && write_int_write_enable_i && (write_exc_bits_i == '0);
    assign fault   = is_idle && write_int_write_enable_i && (write_exc_bits_i != '0);

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        cause = '0;
        for (int i = 31; i >= 0; i--) begin
            if (write_exc_bits_i[i]) cause = 5'(i);
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state            <= IDLE;
            cnt              <= '0;
            kill_o           <= 1'b0;
            redirect_valid_o <= 1'b0;
            mepc_o           <= '0;
            mcause_o         <= '0;
            mtval_o          <= '0;
            minstret_o       <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fault) begin
                        state            <= FLUSH;
                        cnt              <= 4'(KILL_CYCLES - 1);
                        kill_o           <= 1'b1;
                        redirect_valid_o <= 1'b1;
                        mepc_o           <= write_pc_i;
                        mtval_o          <= write_instruction_i;
                        mcause_o         <= {27'd0, cause};
                    end else if (clean) begin
                        minstret_o <= minstret_o + 64'd1;
                        if (write_write_addr_i != '0)
                            regs[write_write_addr_i] <= write_int_write_data_i;
                    end
                end
                FLUSH: begin
                    redirect_valid_o <= 1'b0;
                    if (cnt == '0) begin
                        state  <= IDLE;
                        kill_o <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign redirect_pc_o = redirect_valid_o ? HANDLER_PC : 32'd0;

    always_comb begin
        rs1_data_o = (rs1_addr_i == '0) ? 32'd0 : regs[rs1_addr_i];
        rs2_data_o = (rs2_addr_i == '0) ? 32'd0 : regs[rs2_addr_i];
`ifdef WB_BYPASS_EN
        // Forward only commits that will actually be written at the coming edge.
        if (rsn_i && clean && (write_write_addr_i != '0)) begin
            if (rs1_addr_i == write_write_addr_i) rs1_data_o = write_int_write_data_i;
            if (rs2_addr_i == write_write_addr_i) rs2_data_o = write_int_write_data_i;
        end
`endif
    end

endmodule
